// File: rtl/itch_msg_parser_pkg.sv
// ITCH 5.0 message type codes, required lengths, field offsets and parser state types.
package itch_msg_parser_pkg;

  localparam logic [7:0] ITCH_ADD      = 8'h41;
  localparam logic [7:0] ITCH_ADD_MPID = 8'h46;
  localparam logic [7:0] ITCH_EXEC     = 8'h45;
  localparam logic [7:0] ITCH_DEL      = 8'h44;
  localparam logic [7:0] SIDE_BUY      = 8'h42;

  localparam logic [15:0] LEN_ADD      = 16'd36;
  localparam logic [15:0] LEN_ADD_MPID = 16'd40;
  localparam logic [15:0] LEN_EXEC     = 16'd31;
  localparam logic [15:0] LEN_DEL      = 16'd19;

  // Offsets are body byte indices, byte 0 being the message type.
  localparam logic [15:0] OFF_LOCATE_FIRST     = 16'd1;
  localparam logic [15:0] OFF_LOCATE_LAST      = 16'd2;
  localparam logic [15:0] OFF_REF_FIRST        = 16'd11;
  localparam logic [15:0] OFF_REF_LAST         = 16'd18;
  localparam logic [15:0] OFF_SIDE             = 16'd19;
  localparam logic [15:0] OFF_ADD_SHARES_FIRST = 16'd20;
  localparam logic [15:0] OFF_ADD_SHARES_LAST  = 16'd23;
  localparam logic [15:0] OFF_PRICE_FIRST      = 16'd32;
  localparam logic [15:0] OFF_PRICE_LAST       = 16'd35;
  localparam logic [15:0] OFF_EXEC_SHARES_FIRST = 16'd19;
  localparam logic [15:0] OFF_EXEC_SHARES_LAST  = 16'd22;

  typedef enum logic [1:0] {LEN_HI, LEN_LO, BODY, SKIP} parse_state_t;
  typedef enum logic [1:0] {DONE_NONE, DONE_ADD, DONE_EXEC, DONE_DEL} done_kind_t;

  function automatic logic is_add(input logic [7:0] t);
    return (t == ITCH_ADD) || (t == ITCH_ADD_MPID);
  endfunction

  function automatic logic is_supported(input logic [7:0] t);
    return is_add(t) || (t == ITCH_EXEC) || (t == ITCH_DEL);
  endfunction

  // Zero for unsupported types so they never count as too short.
  function automatic logic [15:0] req_len(input logic [7:0] t);
    case (t)
      ITCH_ADD:      return LEN_ADD;
      ITCH_ADD_MPID: return LEN_ADD_MPID;
      ITCH_EXEC:     return LEN_EXEC;
      ITCH_DEL:      return LEN_DEL;
      default:       return 16'd0;
    endcase
  endfunction

  function automatic done_kind_t kind_of(input logic [7:0] t);
    if (is_add(t)) return DONE_ADD;
    if (t == ITCH_EXEC) return DONE_EXEC;
    if (t == ITCH_DEL) return DONE_DEL;
    return DONE_NONE;
  endfunction

  function automatic logic in_range(input logic [15:0] idx, input logic [15:0] lo,
                                    input logic [15:0] hi);
    return (idx >= lo) && (idx <= hi);
  endfunction

endpackage

// File: rtl/itch_msg_parser_if.sv
// Byte-stream input and decoded-message output bundle; master = feeder/consumer, slave = parser.
interface itch_msg_parser_if #(
  parameter int CNT_WIDTH  = 32,
  parameter int DROP_WIDTH = 16
);
  logic [7:0]            dataIn;
  logic                  dataValidIn;
  logic                  lastIn;
  logic                  addValidOut;
  logic                  delValidOut;
  logic                  execValidOut;
  logic [63:0]           refNumOut;
  logic [15:0]           locateOut;
  logic [31:0]           priceOut;
  logic [31:0]           sharesOut;
  logic                  buySellOut;
  logic [CNT_WIDTH-1:0]  msgCountOut;
  logic [DROP_WIDTH-1:0] dropCountOut;

  modport master (
    output dataIn, dataValidIn, lastIn,
    input  addValidOut, delValidOut, execValidOut, refNumOut, locateOut, priceOut,
           sharesOut, buySellOut, msgCountOut, dropCountOut
  );

  modport slave (
    input  dataIn, dataValidIn, lastIn,
    output addValidOut, delValidOut, execValidOut, refNumOut, locateOut, priceOut,
           sharesOut, buySellOut, msgCountOut, dropCountOut
  );
endinterface

// File: rtl/itch_msg_parser.sv
// Length-prefixed ITCH 5.0 decoder for A/F/E/D; outputs register two edges after the final byte is
// sampled. No backpressure: one byte per valid cycle, back-to-back messages without bubbles.
module itch_msg_parser
  import itch_msg_parser_pkg::*;
#(
  parameter int CNT_WIDTH  = 32,
  parameter int DROP_WIDTH = 16
) (
  input logic              clkIn,
  input logic              rstIn,
  itch_msg_parser_if.slave bus
);

  parse_state_t state, state_nxt;
  logic [7:0]   len_hi, len_hi_nxt;
  logic [15:0]  len, len_nxt;
  logic [15:0]  idx, idx_nxt;
  logic [7:0]   cap_type, type_nxt;
  logic [15:0]  cap_locate, locate_nxt;
  logic [63:0]  cap_ref, ref_nxt;
  logic         cap_side, side_nxt;
  logic [31:0]  cap_shares, shares_nxt;
  logic [31:0]  cap_price, price_nxt;
  done_kind_t   done_q, done_nxt;
  logic         drop_inc;
  logic         last_body;
  logic [7:0]   cur_type;

  logic                  add_valid, del_valid, exec_valid, buy_sell;
  logic [63:0]           ref_num;
  logic [15:0]           locate;
  logic [31:0]           price, shares;
  logic [CNT_WIDTH-1:0]  msg_count;
  logic [DROP_WIDTH-1:0] drop_count;

  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      state      <= LEN_HI;
      len_hi     <= '0;
      len        <= '0;
      idx        <= '0;
      cap_type   <= '0;
      cap_locate <= '0;
      cap_ref    <= '0;
      cap_side   <= 1'b0;
      cap_shares <= '0;
      cap_price  <= '0;
      done_q     <= DONE_NONE;
    end else begin
      state      <= state_nxt;
      len_hi     <= len_hi_nxt;
      len        <= len_nxt;
      idx        <= idx_nxt;
      cap_type   <= type_nxt;
      cap_locate <= locate_nxt;
      cap_ref    <= ref_nxt;
      cap_side   <= side_nxt;
      cap_shares <= shares_nxt;
      cap_price  <= price_nxt;
      done_q     <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    len_hi_nxt = len_hi;
    len_nxt    = len;
    idx_nxt    = idx;
    type_nxt   = cap_type;
    locate_nxt = cap_locate;
    ref_nxt    = cap_ref;
    side_nxt   = cap_side;
    shares_nxt = cap_shares;
    price_nxt  = cap_price;
    done_nxt   = DONE_NONE;
    drop_inc   = 1'b0;
    last_body  = (idx == len - 16'd1);
    cur_type   = (idx == 16'd0) ? bus.dataIn : cap_type;

    if (bus.dataValidIn) begin
      unique case (state)
        LEN_HI: begin
          len_hi_nxt = bus.dataIn;
          if (bus.lastIn) drop_inc = 1'b1;
          else            state_nxt = LEN_LO;
        end
        LEN_LO: begin
          len_nxt    = {len_hi, bus.dataIn};
          idx_nxt    = '0;
          type_nxt   = '0;
          locate_nxt = '0;
          ref_nxt    = '0;
          side_nxt   = 1'b0;
          shares_nxt = '0;
          price_nxt  = '0;
          if ({len_hi, bus.dataIn} == 16'd0) begin
            state_nxt = LEN_HI;
          end else if (bus.lastIn) begin
            drop_inc  = 1'b1;
            state_nxt = LEN_HI;
          end else begin
            state_nxt = BODY;
          end
        end
        BODY, SKIP: begin
          idx_nxt = idx + 16'd1;
          if (state == BODY) begin
            if (idx == 16'd0) type_nxt = bus.dataIn;
            if (in_range(idx, OFF_LOCATE_FIRST, OFF_LOCATE_LAST))
              locate_nxt = {cap_locate[7:0], bus.dataIn};
            if (in_range(idx, OFF_REF_FIRST, OFF_REF_LAST))
              ref_nxt = {cap_ref[55:0], bus.dataIn};
            if (is_add(cur_type)) begin
              if (idx == OFF_SIDE) side_nxt = (bus.dataIn == SIDE_BUY);
              if (in_range(idx, OFF_ADD_SHARES_FIRST, OFF_ADD_SHARES_LAST))
                shares_nxt = {cap_shares[23:0], bus.dataIn};
              if (in_range(idx, OFF_PRICE_FIRST, OFF_PRICE_LAST))
                price_nxt = {cap_price[23:0], bus.dataIn};
            end else if (cur_type == ITCH_EXEC &&
                         in_range(idx, OFF_EXEC_SHARES_FIRST, OFF_EXEC_SHARES_LAST)) begin
              shares_nxt = {cap_shares[23:0], bus.dataIn};
            end
          end

          if (last_body) begin
            state_nxt = LEN_HI;
            if (state == BODY) begin
              if (len < req_len(cur_type)) drop_inc = 1'b1;
              else                         done_nxt = kind_of(cur_type);
            end
          end else if (bus.lastIn) begin
            drop_inc  = 1'b1;
            state_nxt = LEN_HI;
          end else if (state == BODY && idx == 16'd0 && !is_supported(bus.dataIn)) begin
            state_nxt = SKIP;
          end
        end
        default: state_nxt = LEN_HI;
      endcase
    end
  end

  // Captures stay intact for one edge after completion (next LEN_HI never touches them).
  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      add_valid  <= 1'b0;
      del_valid  <= 1'b0;
      exec_valid <= 1'b0;
      ref_num    <= '0;
      locate     <= '0;
      price      <= '0;
      shares     <= '0;
      buy_sell   <= 1'b0;
      msg_count  <= '0;
      drop_count <= '0;
    end else begin
      add_valid  <= (done_q == DONE_ADD);
      del_valid  <= (done_q == DONE_DEL);
      exec_valid <= (done_q == DONE_EXEC);
      if (done_q != DONE_NONE) begin
        ref_num   <= cap_ref;
        locate    <= cap_locate;
        price     <= (done_q == DONE_ADD) ? cap_price : 32'd0;
        shares    <= (done_q == DONE_DEL) ? 32'd0 : cap_shares;
        buy_sell  <= (done_q == DONE_ADD) ? cap_side : 1'b0;
        msg_count <= msg_count + 1'b1;
      end
      if (drop_inc && (drop_count != {DROP_WIDTH{1'b1}}))
        drop_count <= drop_count + 1'b1;
    end
  end

  assign bus.addValidOut  = add_valid;
  assign bus.delValidOut  = del_valid;
  assign bus.execValidOut = exec_valid;
  assign bus.refNumOut    = ref_num;
  assign bus.locateOut    = locate;
  assign bus.priceOut     = price;
  assign bus.sharesOut    = shares;
  assign bus.buySellOut   = buy_sell;
  assign bus.msgCountOut  = msg_count;
  assign bus.dropCountOut = drop_count;

endmodule

// File: tb/tb_itch_msg_parser.sv
// Directed bench for itch_msg_parser: builds ITCH messages byte by byte and checks decoded outputs.
module tb_itch_msg_parser;
  localparam int CNT_WIDTH  = 32;
  localparam int DROP_WIDTH = 16;

  logic clkIn = 1'b0;
  logic rstIn = 1'b0;
  always #5 clkIn = ~clkIn;

  itch_msg_parser_if #(.CNT_WIDTH(CNT_WIDTH), .DROP_WIDTH(DROP_WIDTH)) bus ();

  itch_msg_parser #(.CNT_WIDTH(CNT_WIDTH), .DROP_WIDTH(DROP_WIDTH)) dut (
    .clkIn(clkIn),
    .rstIn(rstIn),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mbuf [0:63];
  int         mlen;
  int         body_len;

  int          add_cnt = 0, del_cnt = 0, exec_cnt = 0, multi_cnt = 0;
  logic [63:0] add_ref;
  logic [15:0] add_loc;
  logic [31:0] add_sh, add_pr;
  logic        add_side;
  time         add_t, del_t;

  always @(negedge clkIn) begin
    if ((int'(bus.addValidOut) + int'(bus.delValidOut) + int'(bus.execValidOut)) > 1)
      multi_cnt++;
    if (bus.addValidOut) begin
      add_cnt++;
      add_ref  = bus.refNumOut;
      add_loc  = bus.locateOut;
      add_sh   = bus.sharesOut;
      add_pr   = bus.priceOut;
      add_side = bus.buySellOut;
      add_t    = $time;
    end
    if (bus.delValidOut) begin
      del_cnt++;
      del_t = $time;
    end
    if (bus.execValidOut) exec_cnt++;
  end

  task automatic put_byte(input int off, input logic [7:0] v);
    if (off < body_len) mbuf[2+off] = v;
  endtask

  task automatic build(input logic [7:0] t, input logic [15:0] len, input logic [15:0] loc,
                       input logic [63:0] rn, input logic [7:0] side,
                       input logic [31:0] sh, input logic [31:0] pr);
    body_len = int'(len);
    mlen     = body_len + 2;
    mbuf[0]  = len[15:8];
    mbuf[1]  = len[7:0];
    for (int i = 2; i < mlen; i++) mbuf[i] = 8'hA5 ^ 8'(i);
    put_byte(0, t);
    put_byte(1, loc[15:8]);
    put_byte(2, loc[7:0]);
    for (int i = 0; i < 8; i++) put_byte(11 + i, rn[63-8*i -: 8]);
    if (t == 8'h41 || t == 8'h46) begin
      put_byte(19, side);
      for (int i = 0; i < 4; i++) put_byte(20 + i, sh[31-8*i -: 8]);
      for (int i = 0; i < 4; i++) put_byte(32 + i, pr[31-8*i -: 8]);
    end else if (t == 8'h45) begin
      for (int i = 0; i < 4; i++) put_byte(19 + i, sh[31-8*i -: 8]);
    end
  endtask

  // Sends the first n bytes of mbuf; lastIn rides on index last_at (-1 for none).
  task automatic send_msg(input int last_at, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clkIn);
      bus.dataIn      = mbuf[i];
      bus.dataValidIn = 1'b1;
      bus.lastIn      = (i == last_at);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clkIn);
      bus.dataValidIn = 1'b0;
      bus.lastIn      = 1'b0;
      bus.dataIn      = 8'h00;
    end
  endtask

  task automatic test_reset();
    bus.dataIn = 8'h00; bus.dataValidIn = 1'b0; bus.lastIn = 1'b0;
    rstIn = 1'b0;
    repeat (3) @(negedge clkIn);
    n_cmp++;
    if ({bus.addValidOut, bus.delValidOut, bus.execValidOut, bus.buySellOut} !== 4'b0) begin
      n_err++; $display("FAIL reset_valids: got %b required 0000",
        {bus.addValidOut, bus.delValidOut, bus.execValidOut, bus.buySellOut});
    end
    n_cmp++;
    if ({bus.refNumOut, bus.locateOut, bus.priceOut, bus.sharesOut} !== 144'h0) begin
      n_err++; $display("FAIL reset_fields: got %h required 0",
        {bus.refNumOut, bus.locateOut, bus.priceOut, bus.sharesOut});
    end
    n_cmp++;
    if (bus.msgCountOut !== 32'd0 || bus.dropCountOut !== 16'd0) begin
      n_err++; $display("FAIL reset_counts: got %0d/%0d required 0/0",
        bus.msgCountOut, bus.dropCountOut);
    end
    rstIn = 1'b1;
    idle(2);
  endtask

  task automatic test_add();
    build(8'h41, 16'd36, 16'h0007, 64'h1234, 8'h42, 32'd100, 32'h0001_86A0);
    send_msg(-1, mlen);
    idle(1);
    n_cmp++;
    if (bus.addValidOut !== 1'b0) begin
      n_err++; $display("FAIL add_latency_early: got %b required 0", bus.addValidOut);
    end
    idle(1);
    n_cmp++;
    if (bus.addValidOut !== 1'b1) begin
      n_err++; $display("FAIL add_pulse: got %b required 1", bus.addValidOut);
    end
    n_cmp++;
    if (bus.refNumOut !== 64'h1234 || bus.locateOut !== 16'h0007) begin
      n_err++; $display("FAIL add_ref_loc: got %h/%h required 1234/0007",
        bus.refNumOut, bus.locateOut);
    end
    n_cmp++;
    if (bus.sharesOut !== 32'd100 || bus.priceOut !== 32'h0001_86A0 || bus.buySellOut !== 1'b1) begin
      n_err++; $display("FAIL add_sh_pr_side: got %0d/%h/%b required 100/000186a0/1",
        bus.sharesOut, bus.priceOut, bus.buySellOut);
    end
    n_cmp++;
    if (bus.msgCountOut !== 32'd1 || bus.dropCountOut !== 16'd0) begin
      n_err++; $display("FAIL add_counts: got %0d/%0d required 1/0",
        bus.msgCountOut, bus.dropCountOut);
    end
    idle(1);
    n_cmp++;
    if (bus.addValidOut !== 1'b0) begin
      n_err++; $display("FAIL add_one_cycle: got %b required 0", bus.addValidOut);
    end
  endtask

  task automatic test_back_to_back();
    int a0, d0;
    a0 = add_cnt; d0 = del_cnt;
    build(8'h46, 16'd40, 16'h0102, 64'hAABB_CCDD_1122_3344, 8'h53, 32'd500, 32'h0000_2710);
    send_msg(-1, mlen);
    build(8'h44, 16'd19, 16'h0009, 64'h1234, 8'h00, 32'd0, 32'd0);
    send_msg(-1, mlen);
    idle(3);
    n_cmp++;
    if (add_cnt !== a0 + 1 || del_cnt !== d0 + 1) begin
      n_err++; $display("FAIL b2b_pulses: got add %0d del %0d required %0d/%0d",
        add_cnt - a0, del_cnt - d0, 1, 1);
    end
    n_cmp++;
    if (add_ref !== 64'hAABB_CCDD_1122_3344 || add_loc !== 16'h0102 || add_side !== 1'b0) begin
      n_err++; $display("FAIL b2b_f_fields: got %h/%h/%b required aabbccdd11223344/0102/0",
        add_ref, add_loc, add_side);
    end
    n_cmp++;
    if (add_sh !== 32'd500 || add_pr !== 32'h0000_2710) begin
      n_err++; $display("FAIL b2b_f_sh_pr: got %0d/%h required 500/00002710", add_sh, add_pr);
    end
    n_cmp++;
    if (del_t - add_t !== 64'd210) begin
      n_err++; $display("FAIL b2b_spacing: got %0t required 210", del_t - add_t);
    end
    n_cmp++;
    if (bus.refNumOut !== 64'h1234 || bus.locateOut !== 16'h0009 || bus.sharesOut !== 32'd0 ||
        bus.priceOut !== 32'd0 || bus.buySellOut !== 1'b0) begin
      n_err++; $display("FAIL b2b_del_fields: got %h/%h/%0d/%0d/%b required 1234/0009/0/0/0",
        bus.refNumOut, bus.locateOut, bus.sharesOut, bus.priceOut, bus.buySellOut);
    end
    n_cmp++;
    if (bus.msgCountOut !== 32'd3 || multi_cnt !== 0) begin
      n_err++; $display("FAIL b2b_count: got %0d multi %0d required 3/0",
        bus.msgCountOut, multi_cnt);
    end
  endtask

  task automatic test_exec();
    int e0;
    e0 = exec_cnt;
    build(8'h45, 16'd31, 16'h0003, 64'h55, 8'h00, 32'd25, 32'd0);
    send_msg(mlen - 1, mlen);
    idle(3);
    n_cmp++;
    if (exec_cnt !== e0 + 1) begin
      n_err++; $display("FAIL exec_pulse: got %0d required 1", exec_cnt - e0);
    end
    n_cmp++;
    if (bus.sharesOut !== 32'd25 || bus.refNumOut !== 64'h55 || bus.locateOut !== 16'h0003 ||
        bus.priceOut !== 32'd0 || bus.buySellOut !== 1'b0) begin
      n_err++; $display("FAIL exec_fields: got %0d/%h/%h/%0d/%b required 25/55/0003/0/0",
        bus.sharesOut, bus.refNumOut, bus.locateOut, bus.priceOut, bus.buySellOut);
    end
    n_cmp++;
    if (bus.msgCountOut !== 32'd4 || bus.dropCountOut !== 16'd0) begin
      n_err++; $display("FAIL exec_counts: got %0d/%0d required 4/0",
        bus.msgCountOut, bus.dropCountOut);
    end
    idle(10);
    n_cmp++;
    if (bus.sharesOut !== 32'd25 || bus.refNumOut !== 64'h55 || exec_cnt !== e0 + 1 ||
        bus.execValidOut !== 1'b0) begin
      n_err++; $display("FAIL exec_hold: got %0d/%h pulses %0d required 25/55/1",
        bus.sharesOut, bus.refNumOut, exec_cnt - e0);
    end
  endtask

  task automatic test_unsupported();
    int a0;
    a0 = add_cnt;
    build(8'h41, 16'd36, 16'h0001, 64'h1, 8'h42, 32'd1, 32'd1);
    send_msg(-1, mlen);
    build(8'h53, 16'd12, 16'h0000, 64'h0, 8'h00, 32'd0, 32'd0);
    send_msg(-1, mlen);
    mbuf[0] = 8'h00; mbuf[1] = 8'h00; mlen = 2;
    send_msg(1, mlen);
    build(8'h41, 16'd36, 16'h0002, 64'h2, 8'h53, 32'd2, 32'd2);
    send_msg(-1, mlen);
    idle(3);
    n_cmp++;
    if (add_cnt !== a0 + 2) begin
      n_err++; $display("FAIL unsup_add_pulses: got %0d required 2", add_cnt - a0);
    end
    n_cmp++;
    if (bus.dropCountOut !== 16'd0 || bus.msgCountOut !== 32'd6) begin
      n_err++; $display("FAIL unsup_counts: got drop %0d msg %0d required 0/6",
        bus.dropCountOut, bus.msgCountOut);
    end
    n_cmp++;
    if (bus.refNumOut !== 64'h2 || bus.locateOut !== 16'h0002 || bus.buySellOut !== 1'b0) begin
      n_err++; $display("FAIL unsup_second_add: got %h/%h/%b required 2/0002/0",
        bus.refNumOut, bus.locateOut, bus.buySellOut);
    end
  endtask

  task automatic test_malformed();
    int a0;
    a0 = add_cnt;
    build(8'h41, 16'd20, 16'h0004, 64'h4, 8'h42, 32'd4, 32'd4);
    send_msg(-1, mlen);
    idle(3);
    n_cmp++;
    if (add_cnt !== a0 || bus.dropCountOut !== 16'd1 || bus.msgCountOut !== 32'd6) begin
      n_err++; $display("FAIL short_drop: got pulses %0d drop %0d msg %0d required 0/1/6",
        add_cnt - a0, bus.dropCountOut, bus.msgCountOut);
    end
    build(8'h41, 16'd36, 16'h0005, 64'h5, 8'h42, 32'd5, 32'd5);
    send_msg(12, 13);
    idle(3);
    n_cmp++;
    if (add_cnt !== a0 || bus.dropCountOut !== 16'd2) begin
      n_err++; $display("FAIL trunc_drop: got pulses %0d drop %0d required 0/2",
        add_cnt - a0, bus.dropCountOut);
    end
    build(8'h41, 16'd36, 16'h0A0B, 64'h0102_0304_0506_0708, 8'h42, 32'd7, 32'h1111_1111);
    send_msg(-1, mlen);
    idle(3);
    n_cmp++;
    if (add_cnt !== a0 + 1 || bus.msgCountOut !== 32'd7 || bus.dropCountOut !== 16'd2) begin
      n_err++; $display("FAIL recover_counts: got pulses %0d msg %0d drop %0d required 1/7/2",
        add_cnt - a0, bus.msgCountOut, bus.dropCountOut);
    end
    n_cmp++;
    if (bus.refNumOut !== 64'h0102_0304_0506_0708 || bus.locateOut !== 16'h0A0B ||
        bus.sharesOut !== 32'd7 || bus.priceOut !== 32'h1111_1111 || bus.buySellOut !== 1'b1) begin
      n_err++; $display("FAIL recover_fields: got %h/%h/%0d/%h/%b required 0102030405060708/0a0b/7/11111111/1",
        bus.refNumOut, bus.locateOut, bus.sharesOut, bus.priceOut, bus.buySellOut);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    build(8'h41, 16'd36, 16'h0006, 64'h6, 8'h42, 32'd6, 32'd6);
    send_msg(-1, 15);
    @(negedge clkIn);
    bus.dataValidIn = 1'b0;
    rstIn = 1'b0;
    #1;
    n_cmp++;
    if ({bus.addValidOut, bus.refNumOut, bus.locateOut, bus.sharesOut, bus.priceOut,
         bus.buySellOut, bus.msgCountOut, bus.dropCountOut} !== 194'h0) begin
      n_err++; $display("FAIL midreset_outputs: got ref %h msg %0d drop %0d required all 0",
        bus.refNumOut, bus.msgCountOut, bus.dropCountOut);
    end
    @(negedge clkIn);
    rstIn = 1'b1;
    idle(2);
    d0 = del_cnt;
    build(8'h44, 16'd19, 16'h0005, 64'h77, 8'h00, 32'd0, 32'd0);
    send_msg(-1, mlen);
    idle(3);
    n_cmp++;
    if (del_cnt !== d0 + 1 || bus.msgCountOut !== 32'd1 || bus.refNumOut !== 64'h77 ||
        bus.locateOut !== 16'h0005 || bus.dropCountOut !== 16'd0) begin
      n_err++; $display("FAIL midreset_del: got pulses %0d msg %0d ref %h loc %h drop %0d required 1/1/77/0005/0",
        del_cnt - d0, bus.msgCountOut, bus.refNumOut, bus.locateOut, bus.dropCountOut);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_exec();
    test_unsupported();
    test_malformed();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
